// File: rtl/tx_ffe_mac_if.sv
// Symbol, coefficient-configuration and equalised-output signals of the TX FFE.
// The master drives symbols and configuration; the slave (the FFE) returns samples.
interface tx_ffe_mac_if #(
  parameter int N_TAPS     = 3,
  parameter int SYM_BITS   = 1,
  parameter int COEF_WIDTH = 8,
  parameter int OUT_WIDTH  = 10
);
  localparam int AW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

  logic        [SYM_BITS-1:0]   in_sym;
  logic                         in_valid;
  logic                         cfg_wr;
  logic        [AW-1:0]         cfg_addr;
  logic signed [COEF_WIDTH-1:0] cfg_data;
  logic                         cfg_commit;
  logic signed [OUT_WIDTH-1:0]  out;
  logic                         out_valid;
  logic        [15:0]           sat_cnt;

  modport master (
    output in_sym, in_valid, cfg_wr, cfg_addr, cfg_data, cfg_commit,
    input  out, out_valid, sat_cnt
  );

  modport slave (
    input  in_sym, in_valid, cfg_wr, cfg_addr, cfg_data, cfg_commit,
    output out, out_valid, sat_cnt
  );
endinterface

// File: rtl/tx_ffe_mac.sv
// Two-stage pipelined TX feed-forward equaliser with double-buffered tap weights.
// Optional macro TX_FFE_SAT_EN: saturating output narrowing plus a sticky clip counter.
module tx_ffe_mac #(
  parameter int N_TAPS     = 3,
  parameter int SYM_BITS   = 1,
  parameter int COEF_WIDTH = 8,
  parameter int OUT_WIDTH  = 10,
  parameter int OUT_SHIFT  = 0,
  parameter int MAIN_TAP   = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  tx_ffe_mac_if.slave  bus
);
  localparam int AW     = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam int LVL_W  = SYM_BITS + 1;
  localparam int PROD_W = COEF_WIDTH + LVL_W;
  localparam int ACC_W  = PROD_W + AW;
  localparam int EXT_W  = (ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH + 1;

  typedef logic signed [COEF_WIDTH-1:0] coef_t;
  typedef logic signed [LVL_W-1:0]      lvl_t;
  typedef logic signed [PROD_W-1:0]     prod_t;

  localparam coef_t MAIN_W = COEF_WIDTH'(1 << (COEF_WIDTH - 2));

  coef_t                        shadow      [N_TAPS];
  coef_t                        shadow_next [N_TAPS];
  coef_t                        active      [N_TAPS];
  lvl_t                         hist        [N_TAPS];
  lvl_t                         hist_next   [N_TAPS];
  prod_t                        prod        [N_TAPS];
  lvl_t                         in_level;
  logic                         s1_valid;
  logic signed [EXT_W-1:0]      acc;
  logic signed [EXT_W-1:0]      shifted;
  logic signed [OUT_WIDTH-1:0]  narrow;
  logic                         clip;

  // 2*code - (2^SYM_BITS - 1), evaluated modulo 2^LVL_W so the result is already signed.
  assign in_level = lvl_t'({bus.in_sym, 1'b0} - LVL_W'((1 << SYM_BITS) - 1));

  // A write in the commit cycle must land in the bank being committed.
  always_comb begin
    shadow_next = shadow;
    if (bus.cfg_wr && int'(bus.cfg_addr) < N_TAPS) begin
      shadow_next[bus.cfg_addr] = bus.cfg_data;
    end
  end

  always_comb begin
    hist_next[0] = in_level;
    for (int k = 1; k < N_TAPS; k++) begin
      hist_next[k] = hist[k-1];
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      acc = acc + EXT_W'(prod[k]);
    end
    shifted = acc >>> OUT_SHIFT;
  end

`ifdef TX_FFE_SAT_EN
  localparam logic signed [EXT_W-1:0] OUT_MAX = EXT_W'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;

  logic [15:0] sat_q;

  always_comb begin
    clip   = 1'b1;
    narrow = shifted[OUT_WIDTH-1:0];
    if (shifted > OUT_MAX) begin
      narrow = OUT_MAX[OUT_WIDTH-1:0];
    end else if (shifted < OUT_MIN) begin
      narrow = OUT_MIN[OUT_WIDTH-1:0];
    end else begin
      clip = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= '0;
    end else if (s1_valid && clip && sat_q != 16'hFFFF) begin
      sat_q <= sat_q + 16'd1;
    end
  end

  assign bus.sat_cnt = sat_q;
`else
  assign clip        = 1'b0;
  assign narrow      = shifted[OUT_WIDTH-1:0];
  assign bus.sat_cnt = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the coefficient banks are a few registers, not RAM, and must come out of reset
      // holding the default main-cursor weight, so every entry is reset explicitly.
      for (int k = 0; k < N_TAPS; k++) begin
        shadow[k] <= (k == MAIN_TAP) ? MAIN_W : '0;
        active[k] <= (k == MAIN_TAP) ? MAIN_W : '0;
        hist[k]   <= '0;
        prod[k]   <= '0;
      end
      s1_valid      <= 1'b0;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      shadow <= shadow_next;
      // Stage 1 samples active[] before this edge, so each output sees exactly one bank.
      if (bus.cfg_commit) begin
        active <= shadow_next;
      end
      if (bus.in_valid) begin
        hist <= hist_next;
        for (int k = 0; k < N_TAPS; k++) begin
          prod[k] <= active[k] * hist_next[k];
        end
      end
      s1_valid      <= bus.in_valid;
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out <= narrow;
      end
    end
  end
endmodule

// File: tb/tb_tx_ffe_mac.sv
// Self-checking bench for tx_ffe_mac: NRZ instance driven from vector tables into a
// scoreboard, plus a PAM4 instance exercising the output narrowing.
module tb_tx_ffe_mac;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tx_ffe_mac_if #(.N_TAPS(3), .SYM_BITS(1), .COEF_WIDTH(8), .OUT_WIDTH(10)) nrz_if ();
  tx_ffe_mac_if #(.N_TAPS(3), .SYM_BITS(2), .COEF_WIDTH(8), .OUT_WIDTH(10)) pam_if ();

  tx_ffe_mac #(.N_TAPS(3), .SYM_BITS(1), .COEF_WIDTH(8), .OUT_WIDTH(10),
               .OUT_SHIFT(0), .MAIN_TAP(0)) u_nrz (.clk(clk), .rst_n(rst_n), .bus(nrz_if));
  tx_ffe_mac #(.N_TAPS(3), .SYM_BITS(2), .COEF_WIDTH(8), .OUT_WIDTH(10),
               .OUT_SHIFT(0), .MAIN_TAP(0)) u_pam (.clk(clk), .rst_n(rst_n), .bus(pam_if));

  typedef struct {
    bit v;
    bit sym;
    bit wr;
    int addr;
    int data;
    bit commit;
    int exp;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int sb[$];
  int pam_got[$];
  int exp_v;

  task automatic check(string name, int actual, int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && nrz_if.out_valid) begin
      if (sb.size() == 0) begin
        check("nrz_unexpected_out_valid", 1, 0);
      end else begin
        exp_v = sb.pop_front();
        check("nrz_out", int'(nrz_if.out), exp_v);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && pam_if.out_valid) pam_got.push_back(int'(pam_if.out));
  end

  task automatic step(bit v, bit sym, bit wr, int addr, int data, bit commit, int exp);
    @(negedge clk);
    nrz_if.in_valid   = v;
    nrz_if.in_sym     = sym;
    nrz_if.cfg_wr     = wr;
    nrz_if.cfg_addr   = addr[1:0];
    nrz_if.cfg_data   = data[7:0];
    nrz_if.cfg_commit = commit;
    if (v) sb.push_back(exp);
  endtask

  task automatic apply(vec_t r);
    step(r.v, r.sym, r.wr, r.addr, r.data, r.commit, r.exp);
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("nrz_drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic clear_inputs();
    nrz_if.in_valid = 0; nrz_if.in_sym = '0; nrz_if.cfg_wr = 0;
    nrz_if.cfg_addr = '0; nrz_if.cfg_data = '0; nrz_if.cfg_commit = 0;
    pam_if.in_valid = 0; pam_if.in_sym = '0; pam_if.cfg_wr = 0;
    pam_if.cfg_addr = '0; pam_if.cfg_data = '0; pam_if.cfg_commit = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    sb.delete();
    pam_got.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  vec_t t_seq2 [3];
  vec_t t_commit [10];
  int   pam_exp [4];
  int   pam_sat_exp;

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    t_seq2 = '{'{1, 1, 0, 0, 0, 0, 48},
               '{1, 1, 0, 0, 0, 0, 32},
               '{1, 0, 0, 0, 0, 0, -64}};
    // Shadow loaded while the default bank is live; commit lands mid-stream on the 3rd symbol.
    t_commit = '{'{0, 0, 1, 0, 16, 0, 0},
                 '{0, 0, 1, 1, 32, 0, 0},
                 '{0, 0, 1, 2, -8, 0, 0},
                 '{1, 1, 0, 0, 0, 0, 64},
                 '{1, 0, 0, 0, 0, 0, -64},
                 '{1, 1, 0, 0, 0, 1, 64},
                 '{1, 1, 0, 0, 0, 0, 56},
                 '{1, 0, 0, 0, 0, 0, 8},
                 '{0, 0, 1, 2, 40, 1, 0},
                 '{1, 1, 0, 0, 0, 0, 24}};
`ifdef TX_FFE_SAT_EN
    pam_exp     = '{381, 511, 511, 381};
    pam_sat_exp = 2;
`else
    pam_exp     = '{381, -262, 119, 381};
    pam_sat_exp = 0;
`endif

    rst_n = 0;
    clear_inputs();
    #1;
    check("reset_out", int'(nrz_if.out), 0);
    check("reset_out_valid", int'(nrz_if.out_valid), 0);
    check("reset_sat_cnt", int'(nrz_if.sat_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Default main cursor alone, both polarities.
    step(1, 1, 0, 0, 0, 0, 64);
    drain();
    do_reset();
    step(1, 0, 0, 0, 0, 0, -64);
    drain();

    // Programmed taps, back-to-back symbols.
    do_reset();
    step(0, 0, 1, 0, 48, 0, 0);
    step(0, 0, 1, 1, -16, 0, 0);
    step(0, 0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    foreach (t_seq2[i]) apply(t_seq2[i]);
    drain();

    // History holds across idle cycles and out holds its last value.
    step(1, 1, 0, 0, 0, 0, 64);
    idle(5);
    check("hold_out", int'(nrz_if.out), 64);
    check("hold_out_valid", int'(nrz_if.out_valid), 0);
    step(1, 1, 0, 0, 0, 0, 32);
    drain();

    // Out-of-range write address is dropped.
    do_reset();
    step(0, 0, 1, 3, -100, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0, 64);
    step(1, 1, 0, 0, 0, 0, 64);
    drain();

    // Commit boundary under traffic, and write+commit in one cycle.
    do_reset();
    foreach (t_commit[i]) apply(t_commit[i]);
    drain();

    // Asynchronous reset while out_valid is high.
    do_reset();
    step(0, 0, 1, 0, 48, 1, 0);
    step(1, 1, 0, 0, 0, 0, 48);
    step(1, 1, 0, 0, 0, 0, 48);
    step(1, 1, 0, 0, 0, 0, 48);
    #1;
    check("midrst_pre_out_valid", int'(nrz_if.out_valid), 1);
    rst_n = 0;
    sb.delete();
    clear_inputs();
    #1;
    check("midrst_out", int'(nrz_if.out), 0);
    check("midrst_out_valid", int'(nrz_if.out_valid), 0);
    @(negedge clk);
    rst_n = 1;
    idle(3);
    step(1, 1, 0, 0, 0, 0, 64);
    step(1, 0, 0, 0, 0, 0, -64);
    drain();
    check("nrz_sat_cnt", int'(nrz_if.sat_cnt), 0);

    // PAM4 narrowing: all taps 127, code 3 three times then code 0.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      pam_if.cfg_wr = 1; pam_if.cfg_addr = 2'(k); pam_if.cfg_data = 8'sd127;
    end
    @(negedge clk);
    pam_if.cfg_wr = 0; pam_if.cfg_commit = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pam_if.cfg_commit = 0; pam_if.in_valid = 1;
      pam_if.in_sym = (k < 3) ? 2'd3 : 2'd0;
    end
    @(negedge clk);
    pam_if.in_valid = 0;
    repeat (4) @(negedge clk);
    check("pam_out_count", pam_got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < pam_got.size()) check($sformatf("pam_out%0d", i), pam_got[i], pam_exp[i]);
    end
    check("pam_sat_cnt", int'(pam_if.sat_cnt), pam_sat_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
